// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: widths, register word indices,
// the "no source" ID and the bridge base address.
package int_ctrl_pkg;

   localparam int unsigned NSRC = 6;
   localparam int unsigned IDW  = 3;
   localparam int unsigned AW   = 3;
   localparam int unsigned DW   = 32;

   localparam logic [AW-1:0] INTC_PEND  = 3'd0;
   localparam logic [AW-1:0] INTC_MASK  = 3'd1;
   localparam logic [AW-1:0] INTC_MODE  = 3'd2;
   localparam logic [AW-1:0] INTC_ACK   = 3'd3;
   localparam logic [AW-1:0] INTC_TAKEN = 3'd4;
   localparam logic [AW-1:0] INTC_ID    = 3'd5;

   localparam logic [IDW-1:0] NOID = 3'd7;

   // Base byte address decoded by the system bridge (word index = addr[4:2]).
   localparam logic [DW-1:0] INTC_BASE = 32'h0000_7F20;

   // Zero-extend a per-source vector onto the data bus.
   function automatic logic [DW-1:0] src_zext(input logic [NSRC-1:0] v);
      return DW'(v);
   endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-set-bit encoder: source 0 has the highest priority; NOID when idle.
module int_prio_enc
   import int_ctrl_pkg::*;
(
   input  logic [NSRC-1:0] req,
   output logic [IDW-1:0]  id,
   output logic            valid
);

   // Scan from the top so the lowest set bit is the last to assign.
   always_comb begin
      id = NOID;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req[i]) id = IDW'(i);
      end
   end

   assign valid = |req;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: per-source level/edge latching, masking onto HWInt,
// and a snapshot of pending sources plus winning ID when the core takes an IRQ.
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter logic [NSRC-1:0] MASK_RST = 6'b000000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] IrqIn,
   input  logic            WE,
   input  logic [AW-1:0]   A,
   input  logic [DW-1:0]   DIn,
   output logic [DW-1:0]   DOut,
   input  logic            IntTaken,
   output logic [NSRC-1:0] HWInt,
   output logic            IrqAny
);

   logic [NSRC-1:0] pend;
   logic [NSRC-1:0] mask;
   logic [NSRC-1:0] mode;
   logic [NSRC-1:0] taken;
   logic [IDW-1:0]  id;
   logic [NSRC-1:0] prev;

   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] ack_clr;
   logic [NSRC-1:0] pend_nxt;
   logic [IDW-1:0]  enc_id;
   logic            enc_valid;
   logic            unused_din;

   assign unused_din = ^DIn[DW-1:NSRC];

   assign rise    = IrqIn & ~prev;
   assign ack_clr = (WE && (A == INTC_ACK)) ? DIn[NSRC-1:0] : '0;

   // Level sources track the line; edge sources hold until ACK, with set beating clear.
   assign pend_nxt = (~mode & IrqIn) | (mode & ((pend & ~ack_clr) | rise));

   assign HWInt  = pend & mask;
   assign IrqAny = |HWInt;

   int_prio_enc u_prio (
      .req   (HWInt),
      .id    (enc_id),
      .valid (enc_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         pend  <= '0;
         mask  <= MASK_RST;
         mode  <= '0;
         taken <= '0;
         id    <= NOID;
         prev  <= '0;
      end else begin
         prev <= IrqIn;
         pend <= pend_nxt;
         if (WE && (A == INTC_MASK)) mask <= DIn[NSRC-1:0];
         if (WE && (A == INTC_MODE)) mode <= DIn[NSRC-1:0];
         if (IntTaken) begin
            taken <= HWInt;
            id    <= enc_valid ? enc_id : NOID;
         end
      end
   end

   // Read mux; ACK and the unused indices read as zero.
   always_comb begin
      DOut = '0;
      case (A)
         INTC_PEND:  DOut = src_zext(pend);
         INTC_MASK:  DOut = src_zext(mask);
         INTC_MODE:  DOut = src_zext(mode);
         INTC_TAKEN: DOut = src_zext(taken);
         INTC_ID:    DOut = DW'(id);
         default:    DOut = '0;
      endcase
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: expectations are queued as stimulus is
// driven and popped when the corresponding output is sampled.
module tb_int_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  IrqIn;
   logic        WE;
   logic [2:0]  A;
   logic [31:0] DIn;
   logic [31:0] DOut;
   logic        IntTaken;
   logic [5:0]  HWInt;
   logic        IrqAny;

   typedef struct {
      string       name;
      logic        is_read;
      logic [2:0]  idx;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   int_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .IrqIn    (IrqIn),
      .WE       (WE),
      .A        (A),
      .DIn      (DIn),
      .DOut     (DOut),
      .IntTaken (IntTaken),
      .HWInt    (HWInt),
      .IrqAny   (IrqAny)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      WE = 1'b1; A = a; DIn = d;
      tick();
      WE = 1'b0; DIn = '0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      A = a;
      #1;
      d = DOut;
   endtask

   task automatic push_rd(input string n, input logic [2:0] idx, input logic [31:0] v);
      exp_t e;
      e.name = n; e.is_read = 1'b1; e.idx = idx; e.val = v;
      sb.push_back(e);
   endtask

   task automatic push_hw(input string n, input logic [5:0] v);
      exp_t e;
      e.name = n; e.is_read = 1'b0; e.idx = '0; e.val = {26'd0, v};
      sb.push_back(e);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      exp_t e;
      push_hw("rst_hwint", 6'h00);
      for (int i = 0; i < 8; i++)
         push_rd($sformatf("rst_idx%0d", i), 3'(i), (i == 5) ? 32'd7 : 32'd0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.is_read) rd(e.idx, d);
         else d = {26'd0, HWInt};
         n_cmp++;
         if (d !== e.val) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, d, e.val);
         end
      end
      n_cmp++;
      if (IrqAny !== 1'b0) begin
         n_err++;
         $display("FAIL rst_irqany: got %b expected 0", IrqAny);
      end
   endtask

   task automatic test_level();
      logic [31:0] d;
      exp_t e;
      wr(3'd1, 32'hFFFF_FFFF);
      push_rd("lvl_mask_zext", 3'd1, 32'h0000_003F);
      e = sb.pop_front(); rd(e.idx, d);
      n_cmp++;
      if (d !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end

      IrqIn = 6'b000100;
      push_hw("lvl_not_yet", 6'b000000);
      e = sb.pop_front(); #1;
      n_cmp++;
      if ({26'd0, HWInt} !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, HWInt, e.val); end

      tick();
      push_hw("lvl_assert", 6'b000100);
      e = sb.pop_front();
      n_cmp++;
      if ({26'd0, HWInt} !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, HWInt, e.val); end

      wr(3'd3, 32'h3F);
      push_hw("lvl_ack_ignored", 6'b000100);
      e = sb.pop_front();
      n_cmp++;
      if ({26'd0, HWInt} !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, HWInt, e.val); end

      IrqIn = 6'b000000;
      tick();
      push_hw("lvl_drop", 6'b000000);
      push_rd("lvl_pend_drop", 3'd0, 32'd0);
      push_rd("lvl_ack_reads0", 3'd3, 32'd0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.is_read) rd(e.idx, d);
         else d = {26'd0, HWInt};
         n_cmp++;
         if (d !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
      end
   endtask

   task automatic test_edge();
      logic [31:0] d;
      exp_t e;
      wr(3'd2, 32'h3F);
      IrqIn = 6'b000100;
      tick();
      IrqIn = 6'b000000;
      tick();
      tick();
      push_rd("edge_pend_held", 3'd0, 32'h4);
      push_hw("edge_hwint_held", 6'b000100);
      push_rd("edge_mode", 3'd2, 32'h3F);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.is_read) rd(e.idx, d);
         else d = {26'd0, HWInt};
         n_cmp++;
         if (d !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
      end
      wr(3'd3, 32'h4);
      push_rd("edge_ack_clear", 3'd0, 32'h0);
      push_hw("edge_ack_hwint", 6'b000000);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.is_read) rd(e.idx, d);
         else d = {26'd0, HWInt};
         n_cmp++;
         if (d !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
      end
   endtask

   task automatic test_collision();
      logic [31:0] d;
      exp_t e;
      IrqIn = 6'b000100;
      WE = 1'b1; A = 3'd3; DIn = 32'h4;
      tick();
      WE = 1'b0; DIn = '0; IrqIn = 6'b000000;
      push_rd("coll_set_wins", 3'd0, 32'h4);
      e = sb.pop_front(); rd(e.idx, d);
      n_cmp++;
      if (d !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
      wr(3'd3, 32'h4);
      push_rd("coll_cleanup", 3'd0, 32'h0);
      e = sb.pop_front(); rd(e.idx, d);
      n_cmp++;
      if (d !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
   endtask

   task automatic test_mask();
      logic [31:0] d;
      exp_t e;
      wr(3'd1, 32'h01);
      IrqIn = 6'b001001;
      tick();
      IrqIn = 6'b000000;
      tick();
      push_rd("mask_pend_latched", 3'd0, 32'h09);
      push_hw("mask_hwint", 6'b000001);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.is_read) rd(e.idx, d);
         else d = {26'd0, HWInt};
         n_cmp++;
         if (d !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
      end
      wr(3'd1, 32'h3F);
      push_hw("mask_open", 6'b001001);
      e = sb.pop_front();
      n_cmp++;
      if ({26'd0, HWInt} !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, HWInt, e.val); end
      n_cmp++;
      if (IrqAny !== 1'b1) begin n_err++; $display("FAIL mask_irqany: got %b expected 1", IrqAny); end
   endtask

   task automatic test_snapshot();
      logic [31:0] d;
      exp_t e;
      wr(3'd3, 32'h3F);
      IrqIn = 6'b101000;
      tick();
      IrqIn = 6'b000000;
      IntTaken = 1'b1;
      tick();
      IntTaken = 1'b0;
      push_rd("snap_taken", 3'd4, 32'h28);
      push_rd("snap_id", 3'd5, 32'd3);
      while (sb.size() > 0) begin
         e = sb.pop_front(); rd(e.idx, d);
         n_cmp++;
         if (d !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
      end
      wr(3'd3, 32'h3F);
      push_rd("snap_hold_taken", 3'd4, 32'h28);
      push_rd("snap_hold_id", 3'd5, 32'd3);
      while (sb.size() > 0) begin
         e = sb.pop_front(); rd(e.idx, d);
         n_cmp++;
         if (d !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
      end
      IntTaken = 1'b1;
      tick();
      IntTaken = 1'b0;
      push_rd("snap_empty_taken", 3'd4, 32'h0);
      push_rd("snap_empty_id", 3'd5, 32'd7);
      while (sb.size() > 0) begin
         e = sb.pop_front(); rd(e.idx, d);
         n_cmp++;
         if (d !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      exp_t e;
      IrqIn = 6'b110000;
      tick();
      IrqIn = 6'b000000;
      IntTaken = 1'b1;
      WE = 1'b1; A = 3'd3; DIn = 32'h3F;
      tick();
      IntTaken = 1'b0; WE = 1'b0; DIn = '0;
      push_rd("b2b_taken", 3'd4, 32'h30);
      push_rd("b2b_id", 3'd5, 32'd4);
      push_rd("b2b_pend", 3'd0, 32'h0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); rd(e.idx, d);
         n_cmp++;
         if (d !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      exp_t e;
      IrqIn = 6'b000010;
      tick();
      IrqIn = 6'b000000;
      IntTaken = 1'b1;
      tick();
      IntTaken = 1'b0;
      reset = 1'b1;
      WE = 1'b1; A = 3'd1; DIn = 32'h15;
      tick();
      reset = 1'b0; WE = 1'b0; DIn = '0;
      push_hw("rmid_hwint", 6'h00);
      push_rd("rmid_pend", 3'd0, 32'h0);
      push_rd("rmid_mask", 3'd1, 32'h0);
      push_rd("rmid_mode", 3'd2, 32'h0);
      push_rd("rmid_taken", 3'd4, 32'h0);
      push_rd("rmid_id", 3'd5, 32'd7);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.is_read) rd(e.idx, d);
         else d = {26'd0, HWInt};
         n_cmp++;
         if (d !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, d, e.val); end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; IrqIn = '0; WE = 1'b0; A = '0; DIn = '0; IntTaken = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      test_reset();
      test_level();
      test_edge();
      test_collision();
      test_mask();
      test_snapshot();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt controller between the six peripheral interrupt lines and the coprocessor's 6-bit HWInt input.
- Latches each source as level or edge, applies a per-source mask and drives HWInt.
- Records which sources were pending when the core took an interrupt, so the handler can read a source ID and acknowledge it over MMIO.
- Sits on the system bridge alongside the timers; the CPU configures it with sw/lw.

Parameters:
- NSRC, 6, number of interrupt sources; fixed to match HWInt width, not meant to be changed.
- MASK_RST, 6'b000000, reset value of the MASK register.
- NOID, 3'd7, ID value meaning "no source pending".

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- IrqIn  input  6  raw interrupt lines from peripherals, synchronous to clk; bit i = source i.
- WE  input  1  bus write enable for this device.
- A  input  3  register word index (byte address bits [4:2]).
- DIn  input  32  bus write data.
- DOut  output  32  bus read data, combinational from A.
- IntTaken  input  1  one-cycle pulse from the CPU when the coprocessor accepts an interrupt request.
- HWInt  output  6  pending & mask, to coprocessor; combinational from registers.
- IrqAny  output  1  |HWInt, for debug LED/trace.

Behaviour:
- Register map, by word index:
  - 0 PEND, read-only; writes ignored.
  - 1 MASK, R/W, bits [5:0].
  - 2 MODE, R/W, bits [5:0]; 1 = edge, 0 = level.
  - 3 ACK, write-only, write-1-to-clear PEND bits; reads 0.
  - 4 TAKEN, read-only.
  - 5 ID, read-only, bits [2:0].
  - 6 and 7 read 0; writes ignored.
- Upper DOut bits are zero-extended.
- Reset: PEND=0, MASK=MASK_RST, MODE=0, TAKEN=0, ID=NOID, prev=0. HWInt=0 and IrqAny=0 after reset.
- prev register: prev <= IrqIn every cycle.
- Edge detect: rise[i] = IrqIn[i] & ~prev[i].
- Level source (MODE[i]=0): PEND[i] <= IrqIn[i] every cycle; ACK writes have no effect on it.
- Edge source (MODE[i]=1):
  - Set PEND[i] on rise[i].
  - Clear on an ACK write with DIn[i]=1.
  - Set and clear in the same cycle: set wins, PEND stays 1.
- Latency: IrqIn rising at edge N makes PEND visible after edge N, so HWInt asserts in cycle N+1.
- HWInt = PEND & MASK, combinational. A MASK write takes effect the cycle after the write edge. Masked sources still latch into PEND.
- MODE change level->edge: PEND[i] is kept; the next rise is needed to re-set it after an ACK.
- MODE change edge->level: PEND[i] follows IrqIn[i] from the next cycle.
- On IntTaken:
  - TAKEN <= HWInt.
  - ID <= index of the lowest set bit of HWInt (source 0 highest priority), or NOID if HWInt==0.
- IntTaken in the same cycle as an ACK write: the snapshot uses the pre-edge HWInt; the ACK clears PEND as normal.
- TAKEN and ID hold until the next IntTaken or reset; ACK does not change them.
- Write priority: a reset in any cycle overrides WE and IntTaken. WE and IntTaken are independent and both take effect in the same cycle.
- No state machine beyond the per-bit latches; all registers update on the rising edge only.

Decomposition:
- Shared package/header holds:
  - register indices (INTC_PEND=0, INTC_MASK=1, INTC_MODE=2, INTC_ACK=3, INTC_TAKEN=4, INTC_ID=5);
  - the NOID constant;
  - the device base address used by the bridge decoder.
- One natural sub-module: int_prio_enc, a combinational 6-to-3 lowest-set-bit encoder with a valid flag. Instantiated once for ID capture.

Test Plan:
- Reset, then read all indices -> PEND=0, MASK=0, MODE=0, TAKEN=0, ID=7, HWInt=0.
- Level mode: write MASK=6'h3F; hold IrqIn=6'b000100 -> HWInt=6'b000100 one cycle later; drop IrqIn -> HWInt=0 one cycle later; ACK ignored.
- Edge mode: MODE=6'h3F, MASK=6'h3F; pulse IrqIn[2] for one cycle -> PEND=6'b000100 held after the pulse; write ACK=6'b000100 -> PEND=0 next cycle.
- Set/clear collision: edge mode; ACK bit 2 in the same cycle IrqIn[2] rises -> PEND[2]=1.
- Mask: MASK=6'b000001, edge pulses on sources 0 and 3 -> PEND=6'b001001, HWInt=6'b000001. Then write MASK=6'h3F -> HWInt=6'b001001 next cycle.
- Snapshot: HWInt=6'b101000; pulse IntTaken -> TAKEN=6'b101000, ID=3. Pulse IntTaken with HWInt=0 -> TAKEN=0, ID=7. Assert reset mid-sequence with WE=1 -> all registers return to reset values, and the write is discarded.
